join_any_monitor: RTL and testbench

JOIN_ANY_MONITOR -- requirements
Module: join_any_monitor

---
 rtl/common_pkg.sv | 24 ++
 rtl/sat_cnt_add.sv | 30 +++
 rtl/join_any_monitor.sv | 149 ++++++++++++++
 tb/tb_join_any_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the join_any completion monitor: FSM states and done_cause bit layout.
package common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_e;

    localparam int unsigned CAUSE_W   = 2;
    localparam int unsigned CAUSE_BAL = 0;
    localparam int unsigned CAUSE_TMO = 1;

    typedef logic [CAUSE_W-1:0] cause_t;

    function automatic cause_t make_cause(input logic bal, input logic tmo);
        cause_t c;
        c            = '0;
        c[CAUSE_BAL] = bal;
        c[CAUSE_TMO] = tmo;
        return c;
    endfunction

endpackage

// File: rtl/sat_cnt_add.sv
// Adds the popcount of a strobe vector to a counter, clipping at all-ones.
// raw_c keeps the unclipped sum so callers can compare true totals.
module sat_cnt_add #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [NUM_IN-1:0] inc_i,
    output logic [CNT_W-1:0]  sum_c,
    output logic [CNT_W:0]    raw_c,
    output logic              sat_c
);

    localparam int unsigned PC_W  = $clog2(NUM_IN + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PC_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            pop = pop + PC_W'(inc_i[i]);
        end
    end

    assign raw_c = SUM_W'(cnt_i) + SUM_W'(pop);
    assign sat_c = raw_c[CNT_W];
    assign sum_c = sat_c ? '1 : raw_c[CNT_W-1:0];

endmodule

// File: rtl/join_any_monitor.sv
// Watches input/output transaction strobes after start and completes on the first of
// balance (equal non-zero counts) or watchdog timeout.
module join_any_monitor
    import common_pkg::*;
#(
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [NUM_IN-1:0] in_valid,
    input  logic              out_valid,
    output logic              done,
    output logic [1:0]        done_cause,
    output logic [CNT_W-1:0]  cnt_in,
    output logic [CNT_W-1:0]  cnt_out,
    output logic [CNT_W-1:0]  timer,
    output logic              err_under,
    output logic              err_sat
);

    localparam int unsigned      SUM_W    = CNT_W + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_in_q, cnt_in_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    cause_t           cause_q, cause_d;
    logic             under_q, under_d;
    logic             sat_q, sat_d;
    logic             done_q;

    logic [CNT_W-1:0] in_sum, out_sum, tmr_sum;
    logic [CNT_W:0]   in_raw, out_raw, tmr_raw;
    logic             in_sat, out_sat, tmr_sat;
    logic             bal, tmo;

    sat_cnt_add #(
        .NUM_IN (NUM_IN),
        .CNT_W  (CNT_W)
    ) u_add_in (
        .cnt_i (cnt_in_q),
        .inc_i (in_valid),
        .sum_c (in_sum),
        .raw_c (in_raw),
        .sat_c (in_sat)
    );

    sat_cnt_add #(
        .NUM_IN (1),
        .CNT_W  (CNT_W)
    ) u_add_out (
        .cnt_i (cnt_out_q),
        .inc_i (out_valid),
        .sum_c (out_sum),
        .raw_c (out_raw),
        .sat_c (out_sat)
    );

    assign tmr_raw = SUM_W'(timer_q) + SUM_W'(1);
    assign tmr_sat = tmr_raw[CNT_W];
    assign tmr_sum = tmr_sat ? '1 : tmr_raw[CNT_W-1:0];

    // Completion tests look at the registered counts, not this cycle's strobes.
    assign bal = (cnt_in_q == cnt_out_q) && (cnt_out_q != '0);
    assign tmo = (timer_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_in_d  = cnt_in_q;
        cnt_out_d = cnt_out_q;
        timer_d   = timer_q;
        cause_d   = cause_q;
        under_d   = under_q;
        sat_d     = sat_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !clear) begin
                    state_d   = ST_ARMED;
                    cnt_in_d  = '0;
                    cnt_out_d = '0;
                    timer_d   = '0;
                    cause_d   = '0;
                    under_d   = 1'b0;
                    sat_d     = 1'b0;
                end
            end
            ST_ARMED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_in_d  = in_sum;
                    cnt_out_d = out_sum;
                    timer_d   = tmr_sum;
                    under_d   = under_q | (out_raw > in_raw);
                    sat_d     = sat_q | in_sat | out_sat | tmr_sat;
                    if (bal || tmo) begin
                        state_d = ST_DONE;
                        cause_d = make_cause(bal, tmo);
                    end
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
            timer_q   <= '0;
            cause_q   <= '0;
            under_q   <= 1'b0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_in_q  <= cnt_in_d;
            cnt_out_q <= cnt_out_d;
            timer_q   <= timer_d;
            cause_q   <= cause_d;
            under_q   <= under_d;
            sat_q     <= sat_d;
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign done       = done_q;
    assign done_cause = cause_q;
    assign cnt_in     = cnt_in_q;
    assign cnt_out    = cnt_out_q;
    assign timer      = timer_q;
    assign err_under  = under_q;
    assign err_sat    = sat_q;

endmodule

// File: tb/tb_join_any_monitor.sv
// Directed and random checks of join_any_monitor against an integer reference model,
// for a default-width instance and a narrow 4-bit instance sharing the same stimulus.
module tb_join_any_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic [3:0] in_valid;
    logic       out_valid;

    logic        a_done, a_under, a_sat;
    logic [1:0]  a_cause;
    logic [15:0] a_cin, a_cout, a_tmr;
    logic        b_done, b_under, b_sat;
    logic [1:0]  b_cause;
    logic [3:0]  b_cin, b_cout, b_tmr;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_DONE  = 2;

    int m_st[2], m_in[2], m_out[2], m_tmr[2], m_cause[2], m_under[2], m_sat[2];
    int m_max[2] = '{65535, 15};
    int m_tmo[2] = '{500, 14};

    join_any_monitor #(.NUM_IN(4), .CNT_W(16), .TIMEOUT_CYC(500)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .out_valid(out_valid),
        .done(a_done), .done_cause(a_cause), .cnt_in(a_cin), .cnt_out(a_cout),
        .timer(a_tmr), .err_under(a_under), .err_sat(a_sat)
    );

    join_any_monitor #(.NUM_IN(4), .CNT_W(4), .TIMEOUT_CYC(14)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .out_valid(out_valid),
        .done(b_done), .done_cause(b_cause), .cnt_in(b_cin), .cnt_out(b_cout),
        .timer(b_tmr), .err_under(b_under), .err_sat(b_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset(input int k);
        m_st[k] = M_IDLE; m_in[k] = 0; m_out[k] = 0; m_tmr[k] = 0;
        m_cause[k] = 0; m_under[k] = 0; m_sat[k] = 0;
    endtask

    // One clock of the monitor's rules, in plain integer arithmetic.
    task automatic m_step(input int k, input logic st, input logic cl,
                          input logic [3:0] iv, input logic ov);
        int  rin, rout, rt;
        bit  bal, tmo;
        case (m_st[k])
            M_IDLE: if (st && !cl) begin
                m_reset(k);
                m_st[k] = M_ARMED;
            end
            M_ARMED: if (cl) begin
                m_st[k] = M_IDLE;
            end else begin
                bal  = (m_in[k] == m_out[k]) && (m_out[k] > 0);
                tmo  = (m_tmr[k] == m_tmo[k] - 1);
                rin  = m_in[k] + $countones(iv);
                rout = m_out[k] + int'(ov);
                rt   = m_tmr[k] + 1;
                if (rout > rin) m_under[k] = 1;
                if (rin > m_max[k] || rout > m_max[k] || rt > m_max[k]) m_sat[k] = 1;
                m_in[k]  = (rin  > m_max[k]) ? m_max[k] : rin;
                m_out[k] = (rout > m_max[k]) ? m_max[k] : rout;
                m_tmr[k] = (rt   > m_max[k]) ? m_max[k] : rt;
                if (bal || tmo) begin
                    m_st[k]    = M_DONE;
                    m_cause[k] = (tmo ? 2 : 0) + (bal ? 1 : 0);
                end
            end
            default: if (cl) m_st[k] = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("a_done",  int'(a_done),  (m_st[0] == M_DONE) ? 1 : 0);
        chk("a_cause", int'(a_cause), m_cause[0]);
        chk("a_cin",   int'(a_cin),   m_in[0]);
        chk("a_cout",  int'(a_cout),  m_out[0]);
        chk("a_tmr",   int'(a_tmr),   m_tmr[0]);
        chk("a_under", int'(a_under), m_under[0]);
        chk("a_sat",   int'(a_sat),   m_sat[0]);
        chk("b_done",  int'(b_done),  (m_st[1] == M_DONE) ? 1 : 0);
        chk("b_cause", int'(b_cause), m_cause[1]);
        chk("b_cin",   int'(b_cin),   m_in[1]);
        chk("b_cout",  int'(b_cout),  m_out[1]);
        chk("b_tmr",   int'(b_tmr),   m_tmr[1]);
        chk("b_under", int'(b_under), m_under[1]);
        chk("b_sat",   int'(b_sat),   m_sat[1]);
    endtask

    task automatic cycle(input logic st, input logic cl, input logic [3:0] iv, input logic ov);
        start = st; clear = cl; in_valid = iv; out_valid = ov;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) m_reset(k);
            else        m_step(k, st, cl, iv, ov);
        end
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = '0; out_valid = 1'b0;
        m_reset(0); m_reset(1);
        #3;
        check_all();
        #9;
        rst_n = 1'b1;

        // Balance after two inputs and two outputs.
        cycle(1, 0, 4'b0000, 0);
        cycle(0, 0, 4'b0101, 1);
        cycle(0, 0, 4'b0000, 1);
        chk("bal2_cout", int'(a_cout), 2);
        chk("bal2_done_early", int'(a_done), 0);
        cycle(0, 0, 4'b0000, 0);
        chk("bal2_done", int'(a_done), 1);
        chk("bal2_cause", int'(a_cause), 1);
        cycle(0, 1, 4'b0000, 0);

        // Twelve in, twelve out.
        cycle(1, 0, 4'b0000, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 4'b1111, 1);
        for (int i = 0; i < 9; i++) cycle(0, 0, 4'b0000, 1);
        cycle(0, 0, 4'b0000, 0);
        chk("bal12_cin", int'(a_cin), 12);
        chk("bal12_cout", int'(a_cout), 12);
        chk("bal12_cause", int'(a_cause), 1);
        chk("bal12_done", int'(a_done), 1);
        cycle(0, 1, 4'b0000, 0);

        // Outputs with no inputs: underflow, never balanced.
        cycle(1, 0, 4'b0000, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 0);
        chk("under_flag", int'(a_under), 1);
        chk("under_no_done", int'(a_done), 0);
        cycle(0, 1, 4'b0000, 0);

        // Watchdog timeout with a single unmatched input.
        cycle(1, 0, 4'b0000, 0);
        cycle(0, 0, 4'b0001, 0);
        begin
            int n = 0;
            while (a_done !== 1'b1 && n < 600) begin
                cycle(0, 0, 4'b0000, 0);
                n++;
            end
            chk("tmo_wait_done", int'(a_done), 1);
        end
        chk("tmo_timer", int'(a_tmr), 500);
        chk("tmo_cause", int'(a_cause), 2);
        chk("tmo4_cause", int'(b_cause), 2);
        chk("tmo4_timer", int'(b_tmr), 14);
        cycle(0, 1, 4'b0000, 0);

        // Narrow counter saturation.
        cycle(1, 0, 4'b0000, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 4'b1111, 0);
        chk("sat4_cin", int'(b_cin), 15);
        chk("sat4_flag", int'(b_sat), 1);
        chk("sat16_cin", int'(a_cin), 20);
        chk("sat16_flag", int'(a_sat), 0);
        cycle(0, 1, 4'b0000, 0);

        // Asynchronous reset while armed, then start with clear.
        cycle(1, 0, 4'b0000, 0);
        cycle(0, 0, 4'b0110, 1);
        cycle(0, 0, 4'b0000, 1);
        rst_n = 1'b0;
        #1;
        m_reset(0); m_reset(1);
        check_all();
        cycle(0, 0, 4'b0011, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 0);
        chk("rst_no_done", int'(a_done), 0);
        cycle(1, 1, 4'b0000, 0);
        cycle(0, 0, 4'b1111, 1);
        chk("startclr_idle_cin", int'(a_cin), 0);
        chk("startclr_idle_tmr", int'(a_tmr), 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic       st, cl, ov;
            logic [3:0] iv;
            st = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 31) == 0);
            iv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            ov = ($urandom_range(0, 3) != 0);
            cycle(st, cl, iv, ov);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
